// File: rtl/naive_bus_arbiter.sv
// Round-robin arbiter sharing one naive-bus slave port among N_MASTER masters.
// A stalled request locks the selection until the slave grants or the master gives up.

module naive_bus_arbiter_lane #(
  parameter int DW  = 32,
  parameter int IW  = 2,
  parameter int IDX = 0
) (
  input  logic [IW-1:0] sel,
  input  logic          rd_hit,
  input  logic          wr_hit,
  input  logic          own_vld,
  input  logic [IW-1:0] own_idx,
  input  logic [DW-1:0] s_rd_data,
  output logic          rd_gnt,
  output logic          wr_gnt,
  output logic [DW-1:0] rd_data
);
  logic is_sel, is_own;

  assign is_sel  = (sel == IW'(IDX));
  assign is_own  = own_vld & (own_idx == IW'(IDX));
  assign rd_gnt  = rd_hit & is_sel;
  assign wr_gnt  = wr_hit & is_sel;
  assign rd_data = is_own ? s_rd_data : '0;
endmodule

module naive_bus_arbiter #(
  parameter int N_MASTER = 3,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_MASTER-1:0]      m_rd_req,
  output logic [N_MASTER-1:0]      m_rd_gnt,
  input  logic [N_MASTER*AW-1:0]   m_rd_addr,
  output logic [N_MASTER*DW-1:0]   m_rd_data,
  input  logic [N_MASTER-1:0]      m_wr_req,
  output logic [N_MASTER-1:0]      m_wr_gnt,
  input  logic [N_MASTER*AW-1:0]   m_wr_addr,
  input  logic [N_MASTER*DW-1:0]   m_wr_data,
  input  logic [N_MASTER*DW/8-1:0] m_wr_be,
  output logic                     s_rd_req,
  input  logic                     s_rd_gnt,
  output logic [AW-1:0]            s_rd_addr,
  input  logic [DW-1:0]            s_rd_data,
  output logic                     s_wr_req,
  input  logic                     s_wr_gnt,
  output logic [AW-1:0]            s_wr_addr,
  output logic [DW-1:0]            s_wr_data,
  output logic [DW/8-1:0]          s_wr_be
);
  localparam int IW = $clog2(N_MASTER);
  localparam int BW = DW / 8;

  logic [N_MASTER-1:0][AW-1:0] rd_addr_v, wr_addr_v;
  logic [N_MASTER-1:0][DW-1:0] wr_data_v, rd_data_v;
  logic [N_MASTER-1:0][BW-1:0] wr_be_v;

  assign rd_addr_v = m_rd_addr;
  assign wr_addr_v = m_wr_addr;
  assign wr_data_v = m_wr_data;
  assign wr_be_v   = m_wr_be;

  logic [IW-1:0]       rr_ptr, lock_idx, rd_own_idx;
  logic                lock_vld, rd_own_vld;
  logic [IW-1:0]       rr_sel, scan_idx, sel, nxt_ptr;
  logic                any_act, sel_vld, rd_hit, wr_hit;
  logic [N_MASTER-1:0] active;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_MASTER) s = s - N_MASTER;
    return IW'(s);
  endfunction

  assign active = m_rd_req | m_wr_req;

  // Scan from the farthest offset back to rr_ptr so the nearest active master wins.
  always_comb begin
    rr_sel   = rr_ptr;
    any_act  = 1'b0;
    scan_idx = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      scan_idx = wrap_add(rr_ptr, k);
      if (active[scan_idx]) begin
        rr_sel  = scan_idx;
        any_act = 1'b1;
      end
    end
  end

  assign sel     = lock_vld ? lock_idx : rr_sel;
  assign sel_vld = rst_n & (lock_vld ? active[lock_idx] : any_act);
  assign nxt_ptr = wrap_add(sel, 1);

  // Read wins over write for a master asserting both; its write waits for a later turn.
  assign s_rd_req  = sel_vld & m_rd_req[sel];
  assign s_wr_req  = sel_vld & m_wr_req[sel] & ~m_rd_req[sel];
  assign s_rd_addr = sel_vld ? rd_addr_v[sel] : '0;
  assign s_wr_addr = sel_vld ? wr_addr_v[sel] : '0;
  assign s_wr_data = sel_vld ? wr_data_v[sel] : '0;
  assign s_wr_be   = sel_vld ? wr_be_v[sel]   : '0;

  assign rd_hit = s_rd_req & s_rd_gnt;
  assign wr_hit = s_wr_req & s_wr_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lock_vld   <= 1'b0;
      lock_idx   <= '0;
      rd_own_vld <= 1'b0;
      rd_own_idx <= '0;
    end else begin
      if (rd_hit | wr_hit) begin
        rr_ptr   <= nxt_ptr;
        lock_vld <= 1'b0;
      end else if (s_rd_req | s_wr_req) begin
        lock_vld <= 1'b1;
        lock_idx <= sel;
      end else begin
        // Locked master withdrew (or nothing pending): re-arbitrate next cycle.
        lock_vld <= 1'b0;
      end
      rd_own_vld <= rd_hit;
      if (rd_hit) rd_own_idx <= sel;
    end
  end

  for (genvar i = 0; i < N_MASTER; i++) begin : g_lane
    naive_bus_arbiter_lane #(.DW(DW), .IW(IW), .IDX(i)) u_lane (
      .sel       (sel),
      .rd_hit    (rd_hit),
      .wr_hit    (wr_hit),
      .own_vld   (rd_own_vld),
      .own_idx   (rd_own_idx),
      .s_rd_data (s_rd_data),
      .rd_gnt    (m_rd_gnt[i]),
      .wr_gnt    (m_wr_gnt[i]),
      .rd_data   (rd_data_v[i])
    );
  end

  assign m_rd_data = rd_data_v;
endmodule

// File: doc/naive_bus_arbiter.md
Name: naive_bus_arbiter

Overview:
- Shares one naive-bus slave port among N_MASTER requesters: ISP UART debug master, CPU instruction port and CPU data port.
- Sits in soc_top between the masters and the bus router. Lets the ISP UART load and inspect memory while the core runs.
- Round-robin arbitration with request locking while the slave stalls.
- Routes read data back to the granted master one cycle after grant.

Parameters:
- N_MASTER, 3, number of masters (2..8); index 0 = ISP UART.
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_rd_req  in  N_MASTER  per-master read request.
- m_rd_gnt  out  N_MASTER  per-master read grant.
- m_rd_addr  in  N_MASTER*AW  per-master read address; slice i = master i.
- m_rd_data  out  N_MASTER*DW  per-master read data.
- m_wr_req  in  N_MASTER  per-master write request.
- m_wr_gnt  out  N_MASTER  per-master write grant.
- m_wr_addr  in  N_MASTER*AW  per-master write address.
- m_wr_data  in  N_MASTER*DW  per-master write data.
- m_wr_be  in  N_MASTER*DW/8  per-master byte enables.
- s_rd_req  out  1  to slave.
- s_rd_gnt  in  1  from slave.
- s_rd_addr  out  AW  to slave.
- s_rd_data  in  DW  from slave; valid the cycle after s_rd_gnt.
- s_wr_req  out  1  to slave.
- s_wr_gnt  in  1  from slave.
- s_wr_addr  out  AW  to slave.
- s_wr_data  out  DW  to slave.
- s_wr_be  out  DW/8  to slave.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- State registers:
  - rr_ptr (log2 N_MASTER bits).
  - lock_vld, lock_idx.
  - rd_own_vld, rd_own_idx.
  - All reset to 0.
- Master active = m_rd_req[i] | m_wr_req[i].
  - If both are asserted, read takes precedence for that master; its write stays pending.
- Selection, combinational:
  - If lock_vld, sel = lock_idx.
  - Else sel = first active master scanning rr_ptr, rr_ptr+1, ... wrapping modulo N_MASTER.
  - No active master: all s_*_req = 0, all m_*_gnt = 0, s_* addr/data/be driven 0.
- Forwarding:
  - s_rd_req = m_rd_req[sel].
  - s_wr_req = m_wr_req[sel] & ~m_rd_req[sel].
  - Address, data and be come from slice sel.
  - s_rd_req and s_wr_req are never both 1.
- Grant, zero latency:
  - m_rd_gnt[sel] = s_rd_gnt & s_rd_req.
  - m_wr_gnt[sel] = s_wr_gnt & s_wr_req.
  - All other gnt bits are 0; at most one gnt bit set per cycle across both vectors.
- On any grant:
  - rr_ptr <= (sel+1) mod N_MASTER.
  - lock_vld <= 0.
- Request with no grant (slave stall):
  - lock_vld <= 1, lock_idx <= sel.
  - The slave sees the same master until it grants; no switching mid-stall.
- Lock release without grant: if the locked master drops its request, lock_vld <= 0 and selection re-arbitrates in the next cycle.
- Read return:
  - On a read grant, rd_own_vld <= 1 and rd_own_idx <= sel; otherwise rd_own_vld <= 0.
  - m_rd_data slice rd_own_idx = s_rd_data when rd_own_vld; every other slice = 0.
  - Back-to-back read grants to different masters return data to the correct owner each cycle.
- Fairness: a continuously requesting master is granted within N_MASTER grants.
- rr_ptr wraps from N_MASTER-1 to 0.
- Reset mid-stall clears lock and ownership; outputs drop to 0 asynchronously.
- No combinational path from s_rd_data to any gnt signal.

Test Plan:
- Reset; then m0 rd_req, addr 0x0000_0100, slave grants immediately, s_rd_data=0xDEADBEEF next cycle -> m_rd_gnt=3'b001 in the same cycle; next cycle m0 rd_data slice = 0xDEADBEEF, slices 1 and 2 = 0.
- All three masters issue reads continuously, s_rd_gnt=1 -> grants rotate 001,010,100,001; each rd_data slice matches its own one-cycle-delayed grant.
- m1 writes 0x12345678 with be=4'b0011, s_wr_gnt held 0 for 3 cycles, m2 requests meanwhile -> slave sees m1's addr/data/be stable for all 4 cycles; m1 granted on cycle 4; m2 granted next cycle.
- m0 asserts rd_req and wr_req together, slave always grants -> read granted first, s_wr_req=0 that cycle; write granted on m0's next turn.
- Stall locked on m2, then m2 drops its request while m0 requests -> lock cleared; m0 selected the following cycle.
- Assert rst_n=0 mid-stall and mid-read-return -> all gnt, s_*_req and rd_data go to 0 immediately; after release, arbitration restarts at m0.
